// File: rtl/data_inf_partition_burst_if.sv
// Purpose: bundles the descriptor, partition-pulse, beat and completion handshakes of the burst expander.
// Latency: none; wiring only.
// Backpressure: carries the valid/ready pairs unchanged between the two sides.
interface data_inf_partition_burst_if #(
  parameter int LSIZE  = 8,
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 16
);
  logic                          desc_valid;
  logic                          desc_ready;
  logic [IDSIZE+4+ASIZE+LSIZE-1:0] desc_data;
  logic                          pp_valid;
  logic                          pp_ready;
  logic                          beat_valid;
  logic                          beat_ready;
  logic [IDSIZE+4-1:0]           beat_id;
  logic [ASIZE-1:0]              beat_addr;
  logic                          beat_last;
  logic                          cmpl_valid;
  logic                          cmpl_ready;
  logic [IDSIZE+4-1:0]           cmpl_id;
  logic                          stall_flag;

  // Expander side: consumes descriptors and pulses, produces beats and completions.
  modport slave (
    input  desc_valid, desc_data, pp_valid, beat_ready, cmpl_ready,
    output desc_ready, pp_ready, beat_valid, beat_id, beat_addr, beat_last,
           cmpl_valid, cmpl_id, stall_flag
  );

  // Surrounding logic: issues descriptors and pulses, sinks beats and completions.
  modport master (
    output desc_valid, desc_data, pp_valid, beat_ready, cmpl_ready,
    input  desc_ready, pp_ready, beat_valid, beat_id, beat_addr, beat_last,
           cmpl_valid, cmpl_id, stall_flag
  );
endinterface

// File: rtl/data_inf_partition_burst.sv
// Purpose: expands {id,addr,len} descriptors into len+1 addressed beats and reports completion; optional stall watchdog via DATA_INF_PARTITION_TIMEOUT_EN.
// Latency: first beat one cycle after the descriptor handshake; completion one cycle after the last beat.
// Backpressure: beats hold while beat_ready is low; descriptors and partition pulses are only accepted when idle.
module data_inf_partition_burst #(
  parameter int LSIZE     = 8,
  parameter int IDSIZE    = 4,
  parameter int ASIZE     = 16,
  parameter int ADDR_STEP = 1,
  parameter int TIMEOUT   = 200
) (
  input  logic                        clock,
  input  logic                        rst,
  data_inf_partition_burst_if.slave   bus
);

  localparam int IW = IDSIZE + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CMPL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IW-1:0]    id_q;
  logic [IW-1:0]    cmpl_id_q;
  logic [ASIZE-1:0] addr_q;
  logic [LSIZE-1:0] len_q;
  logic [LSIZE-1:0] cnt_q;

  logic             desc_rdy;
  logic             pp_rdy;
  logic             beat_vld;
  logic             cmpl_vld;
  logic             beat_lst;
  logic             desc_fire;
  logic             beat_fire;

  // Descriptor field split: len in the LSBs, then addr, id on top.
  logic [IW-1:0]    d_id;
  logic [ASIZE-1:0] d_addr;
  logic [LSIZE-1:0] d_len;

  assign d_len  = bus.desc_data[0 +: LSIZE];
  assign d_addr = bus.desc_data[LSIZE +: ASIZE];
  assign d_id   = bus.desc_data[LSIZE+ASIZE +: IW];

  // State register; reset abandons any burst without a completion.
  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    desc_rdy  = 1'b0;
    pp_rdy    = 1'b0;
    beat_vld  = 1'b0;
    cmpl_vld  = 1'b0;
    case (state)
      IDLE: begin
        // A partition pulse is simply absorbed; it only matters that it
        // waits here until no burst is in flight.
        desc_rdy = ~rst;
        pp_rdy   = ~rst;
        if (bus.desc_valid && !rst) state_nxt = BURST;
      end
      BURST: begin
        beat_vld = 1'b1;
        if (bus.beat_ready && (cnt_q == len_q)) state_nxt = CMPL;
      end
      CMPL: begin
        cmpl_vld = 1'b1;
        if (bus.cmpl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat_lst  = beat_vld && (cnt_q == len_q);
  assign desc_fire = desc_rdy && bus.desc_valid;
  assign beat_fire = beat_vld && bus.beat_ready;

  // Descriptor capture, beat counter/address advance and completion id.
  always_ff @(posedge clock) begin
    if (rst) begin
      id_q      <= '0;
      cmpl_id_q <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      if (desc_fire) begin
        id_q   <= d_id;
        addr_q <= d_addr;
        len_q  <= d_len;
        cnt_q  <= '0;
      end else if (beat_fire) begin
        // Counter only feeds the last-beat compare, so wrap after the
        // final beat of a full-length burst is harmless.
        cnt_q  <= cnt_q + LSIZE'(1);
        addr_q <= addr_q + ASIZE'(ADDR_STEP);
        if (beat_lst) cmpl_id_q <= id_q;
      end
    end
  end

  assign bus.desc_ready = desc_rdy;
  assign bus.pp_ready   = pp_rdy;
  assign bus.beat_valid = beat_vld;
  assign bus.beat_last  = beat_lst;
  assign bus.beat_id    = id_q;
  assign bus.beat_addr  = addr_q;
  assign bus.cmpl_valid = cmpl_vld;
  assign bus.cmpl_id    = cmpl_id_q;

`ifdef DATA_INF_PARTITION_TIMEOUT_EN
  logic [9:0] stall_cnt;
  logic       stall_q;
  logic       stalling;

  assign stalling = beat_vld && !bus.beat_ready;

  // Watchdog: count consecutive stalled beat cycles; the flag sets on the
  // cycle the count passes TIMEOUT and stays until reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      if (stalling) begin
        if (stall_cnt != 10'h3FF) stall_cnt <= stall_cnt + 10'd1;
      end else begin
        stall_cnt <= '0;
      end
      if (stalling && (stall_cnt >= 10'(TIMEOUT))) stall_q <= 1'b1;
    end
  end

  assign bus.stall_flag = stall_q;
`else
  assign bus.stall_flag = 1'b0;
`endif

endmodule

// File: tb/tb_data_inf_partition_burst.sv
// Purpose: directed plus randomized bench for the descriptor burst expander with a descriptor-level reference model.
// Latency: checks first beat one cycle after accept and completion one cycle after the last beat.
// Backpressure: drives random beat_ready and delayed cmpl_ready; checks outputs hold while stalled.
module tb_data_inf_partition_burst;

  localparam int LSIZE     = 8;
  localparam int IDSIZE    = 4;
  localparam int ASIZE     = 16;
  localparam int ADDR_STEP = 1;
  localparam int TIMEOUT   = 200;
`ifdef DATA_INF_PARTITION_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock;
  logic rst;
  int   total;
  int   bad;
  int   hs_cnt;
  int   pp_cnt;

  data_inf_partition_burst_if #(.LSIZE(LSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE)) bus ();

  data_inf_partition_burst #(
    .LSIZE(LSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE),
    .ADDR_STEP(ADDR_STEP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count accepted beats and partition pulses as seen on the wires.
  always @(posedge clock) begin
    if (!rst) begin
      if (bus.beat_valid && bus.beat_ready) hs_cnt <= hs_cnt + 1;
      if (bus.pp_valid && bus.pp_ready)     pp_cnt <= pp_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From an idle negedge: present one descriptor and leave it after acceptance.
  task automatic start_desc(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len);
    chk("idle_desc_ready", bus.desc_ready, 1);
    chk("idle_pp_ready", bus.pp_ready, 1);
    bus.desc_data  = {id, a, len};
    bus.desc_valid = 1'b1;
    @(negedge clock);
    bus.desc_valid = 1'b0;
  endtask

  // Expected beat k: addr = base + k*STEP modulo 2^ASIZE, last only when k == len.
  task automatic burst(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len, input bit rnd);
    int idx = 0;
    int guard = 0;
    logic [15:0] ea;
    logic br;
    while (idx <= int'(len) && guard < 4000) begin
      ea = 16'(int'(a) + idx * ADDR_STEP);
      chk("beat_valid", bus.beat_valid, 1);
      chk("beat_addr", bus.beat_addr, ea);
      chk("beat_id", bus.beat_id, id);
      chk("beat_last", bus.beat_last, (idx == int'(len)) ? 1 : 0);
      chk("pp_ready_busy", bus.pp_ready, 0);
      chk("desc_ready_busy", bus.desc_ready, 0);
      br = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.beat_ready = br;
      @(negedge clock);
      if (br) idx++;
      guard++;
    end
    bus.beat_ready = 1'b0;
    if (guard >= 4000) chk("burst_budget", guard, 0);
  endtask

  // From the negedge after the last beat: completion must be up and hold until accepted.
  task automatic finish_cmpl(input logic [7:0] id);
    int w;
    chk("beat_drop", bus.beat_valid, 0);
    chk("cmpl_valid", bus.cmpl_valid, 1);
    chk("cmpl_id", bus.cmpl_id, id);
    chk("cmpl_desc_ready", bus.desc_ready, 0);
    chk("cmpl_pp_ready", bus.pp_ready, 0);
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      @(negedge clock);
      chk("cmpl_hold", bus.cmpl_valid, 1);
      chk("cmpl_hold_pp", bus.pp_ready, 0);
    end
    bus.cmpl_ready = 1'b1;
    @(negedge clock);
    bus.cmpl_ready = 1'b0;
    chk("cmpl_done", bus.cmpl_valid, 0);
    chk("back_idle", bus.desc_ready, 1);
  endtask

  task automatic run_desc(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len, input bit rnd);
    int hs0;
    hs0 = hs_cnt;
    start_desc(id, a, len);
    burst(id, a, len, rnd);
    finish_cmpl(id);
    chk("beat_count", hs_cnt - hs0, int'(len) + 1);
  endtask

  initial begin
    int hs0;
    int pp0;
    logic [7:0]  rid;
    logic [15:0] raddr;
    logic [7:0]  rlen;
    total = 0;
    bad = 0;
    hs_cnt = 0;
    pp_cnt = 0;
    rst = 1'b1;
    bus.desc_valid = 1'b0;
    bus.desc_data  = '0;
    bus.pp_valid   = 1'b0;
    bus.beat_ready = 1'b0;
    bus.cmpl_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst_desc_ready", bus.desc_ready, 0);
    chk("rst_pp_ready", bus.pp_ready, 0);
    chk("rst_beat_valid", bus.beat_valid, 0);
    chk("rst_beat_last", bus.beat_last, 0);
    chk("rst_cmpl_valid", bus.cmpl_valid, 0);
    chk("rst_stall", bus.stall_flag, 0);
    chk("rst_beat_id", bus.beat_id, 0);
    chk("rst_beat_addr", bus.beat_addr, 0);
    chk("rst_cmpl_id", bus.cmpl_id, 0);
    rst = 1'b0;
    @(negedge clock);

    // Basic burst with continuous ready.
    run_desc(8'h13, 16'h0100, 8'd3, 1'b0);
    // Single beat at the top of the address space.
    run_desc(8'h21, 16'hFFFF, 8'd0, 1'b0);
    // Address wrap across the top.
    run_desc(8'h32, 16'hFFFE, 8'd2, 1'b0);
    // Random backpressure over eight beats.
    run_desc(8'h47, 16'h1234, 8'd7, 1'b1);
    // Longest burst.
    run_desc(8'hF0, 16'h8000, 8'hFF, 1'b0);

    // Pulse and descriptor together; a held pulse waits for the next idle.
    pp0 = pp_cnt;
    bus.pp_valid = 1'b1;
    start_desc(8'h5C, 16'h0040, 8'd2);
    chk("pp_accept_with_desc", pp_cnt, pp0 + 1);
    burst(8'h5C, 16'h0040, 8'd2, 1'b1);
    finish_cmpl(8'h5C);
    chk("pp_blocked_busy", pp_cnt, pp0 + 1);
    @(negedge clock);
    chk("pp_accept_idle", pp_cnt, pp0 + 2);
    bus.pp_valid = 1'b0;

    // Reset on the third beat of a six-beat burst.
    hs0 = hs_cnt;
    start_desc(8'h66, 16'h0200, 8'd5);
    bus.beat_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("pre_rst_addr", bus.beat_addr, 16'h0202);
    rst = 1'b1;
    @(negedge clock);
    chk("midrst_beat_valid", bus.beat_valid, 0);
    chk("midrst_cmpl_valid", bus.cmpl_valid, 0);
    chk("midrst_beat_addr", bus.beat_addr, 0);
    chk("midrst_beat_id", bus.beat_id, 0);
    chk("midrst_desc_ready", bus.desc_ready, 0);
    rst = 1'b0;
    bus.beat_ready = 1'b0;
    @(negedge clock);
    chk("postrst_cmpl_valid", bus.cmpl_valid, 0);
    chk("postrst_idle", bus.desc_ready, 1);
    chk("midrst_beats", hs_cnt - hs0, 2);

    // Long stall: watchdog sets on cycle TIMEOUT+2 when enabled, never otherwise.
    start_desc(8'h5A, 16'h2000, 8'd0);
    for (int k = 1; k <= 250; k++) begin
      if (k == TIMEOUT + 1) chk("stall_before", bus.stall_flag, 0);
      if (k == TIMEOUT + 2) chk("stall_at", bus.stall_flag, TO_EN);
      if (k == 250) begin
        chk("stall_end", bus.stall_flag, TO_EN);
        chk("stall_hold_valid", bus.beat_valid, 1);
        chk("stall_hold_addr", bus.beat_addr, 16'h2000);
        chk("stall_hold_last", bus.beat_last, 1);
      end
      @(negedge clock);
    end
    bus.beat_ready = 1'b1;
    @(negedge clock);
    bus.beat_ready = 1'b0;
    finish_cmpl(8'h5A);
    chk("stall_sticky", bus.stall_flag, TO_EN);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    chk("stall_cleared", bus.stall_flag, 0);

    // Random descriptors under random backpressure.
    for (int n = 0; n < 6; n++) begin
      rid   = 8'($urandom_range(0, 255));
      raddr = 16'($urandom);
      rlen  = 8'($urandom_range(0, 15));
      run_desc(rid, raddr, rlen, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
